mmio_uart_tx: RTL and testbench



---
 rtl/mmio_uart_tx.sv | 173 +++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a store-fed FIFO and combinational STATUS read.
// Define MMIO_UART_PARITY_EN to insert an even-parity bit between the data and stop bits.
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
   parameter int          CLK_DIV    = 434,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dm_wr,
   input  logic        dm_rd,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        hit,
   output logic [31:0] rdata,
   output logic        tx,
   output logic        busy
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int DW = $clog2(CLK_DIV);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_STOP
`ifdef MMIO_UART_PARITY_EN
      , S_PARITY
`endif
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          busy_q, busy_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic [7:0]    mem_q [FIFO_DEPTH];

   logic full, empty, div_end, pop, push, push_req, stat_wr, ovf_set;
   logic [7:0]  head;
   logic [7:0]  cnt8;
   logic [31:0] status;
   logic        par_flag;
   logic        unused_ok;

   assign hit      = (addr[31:3] == BASE_ADDR[31:3]);
   assign full     = (cnt_q == (AW+1)'(FIFO_DEPTH));
   assign empty    = (cnt_q == '0);
   assign div_end  = (div_q == DW'(CLK_DIV - 1));
   assign head     = mem_q[rd_ptr_q];
   assign push_req = dm_wr && hit && !addr[2];
   assign stat_wr  = dm_wr && hit && addr[2];

   // A byte leaves the FIFO when idle, or at the end of a stop bit so frames abut.
   assign pop      = !empty && ((state_q == S_IDLE) || (state_q == S_STOP && div_end));
   assign push     = push_req && (!full || pop);
   assign ovf_set  = push_req && full && !pop;

`ifdef MMIO_UART_PARITY_EN
   logic par_q, par_d;
   assign par_flag = 1'b1;
   always_comb begin
      par_d = par_q;
      if (pop) par_d = ^head;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) par_q <= 1'b0;
      else        par_q <= par_d;
   end
`else
   assign par_flag = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         div_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage needs no reset: the pointers define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wdata[7:0];
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (!empty) state_d = S_START;
         S_START: if (div_end) state_d = S_DATA;
         S_DATA:
            if (div_end && bit_q == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
               state_d = S_PARITY;
`else
               state_d = S_STOP;
`endif
            end
`ifdef MMIO_UART_PARITY_EN
         S_PARITY: if (div_end) state_d = S_STOP;
`endif
         S_STOP:  if (div_end) state_d = empty ? S_IDLE : S_START;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath and FIFO bookkeeping
   always_comb begin
      div_d    = (state_q == S_IDLE || div_end) ? '0 : div_q + DW'(1);
      bit_d    = bit_q;
      shift_d  = shift_q;
      if (pop) begin
         shift_d = head;
         bit_d   = '0;
      end else if (state_q == S_DATA && div_end) begin
         shift_d = shift_q >> 1;
         bit_d   = bit_q + 3'd1;
      end
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
      ovf_d = ovf_q;
      if (stat_wr && wdata[3]) ovf_d = 1'b0;
      if (ovf_set)             ovf_d = 1'b1;
   end

   // Output logic: the line level follows the state being entered.
   always_comb begin
      case (state_d)
         S_START:    tx_d = 1'b0;
         S_DATA:     tx_d = shift_d[0];
`ifdef MMIO_UART_PARITY_EN
         S_PARITY:   tx_d = par_q;
`endif
         default:    tx_d = 1'b1;
      endcase
      busy_d = (state_q != S_IDLE) || !empty;
   end

   assign cnt8   = 8'(cnt_q);
   assign status = {16'h0, cnt8, 3'b000, par_flag, ovf_q, busy_q, empty, full};
   assign rdata  = (hit && dm_rd && addr[2]) ? status : 32'h0;
   assign tx     = tx_q;
   assign busy   = busy_q;

   assign unused_ok = ^{addr[1:0], wdata[31:8]};
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: decode vector table, directed frame/overflow/reset sequences,
// and random traffic, all checked cycle by cycle against a queue-based frame model.
module tb_mmio_uart_tx;
   localparam int CD    = 4;
   localparam int DEPTH = 8;
`ifdef MMIO_UART_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int          FLEN = (10 + PAR) * CD;
   localparam logic [31:0] BASE = 32'hFFFF_0000;
   localparam logic [31:0] PBIT = (PAR != 0) ? 32'h10 : 32'h0;
   localparam logic [31:0] ST_IDLE = 32'h2 | PBIT;

   logic        clk = 0, rst_n = 0, dm_wr = 0, dm_rd = 0;
   logic [31:0] addr = 0, wdata = 0;
   logic        hit, tx, busy;
   logic [31:0] rdata;

   always #5 clk = ~clk;

   mmio_uart_tx #(.BASE_ADDR(BASE), .CLK_DIV(CD), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .dm_wr(dm_wr), .dm_rd(dm_rd), .addr(addr),
      .wdata(wdata), .hit(hit), .rdata(rdata), .tx(tx), .busy(busy));

   int checks = 0, errors = 0;

   // Reference model: a byte queue plus the currently transmitted frame as a bit vector.
   logic [7:0]  q[$];
   logic        m_active, m_ovf, m_busy;
   int          m_t;
   logic [10:0] m_bits;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_active = 0; m_ovf = 0; m_busy = 0; m_t = 0; m_bits = '1;
   endtask

   function automatic logic m_tx();
      return m_active ? m_bits[m_t / CD] : 1'b1;
   endfunction

   function automatic logic [31:0] m_status();
      int sz = q.size();
      return {16'h0, 8'(sz), 3'b000, 1'(PAR), m_ovf, m_busy, sz == 0, sz == DEPTH};
   endfunction

   task automatic start_frame(logic [7:0] d);
      m_bits = '1;
      m_bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) m_bits[1+i] = d[i];
      if (PAR != 0) m_bits[9] = ^d;
      m_active = 1; m_t = 0;
   endtask

   task automatic model_step();
      int   sz;
      logic pop, busy_n, mhit, set;
      if (!rst_n) begin model_reset(); return; end
      sz = q.size(); pop = 0; set = 0;
      busy_n = m_active || sz > 0;
      if (!m_active) begin
         if (sz > 0) pop = 1;
      end else if (m_t == FLEN - 1) begin
         if (sz > 0) pop = 1; else m_active = 0;
      end else m_t++;
      mhit = addr[31:3] == BASE[31:3];
      if (pop) start_frame(q.pop_front());
      if (dm_wr && mhit && !addr[2]) begin
         if (sz < DEPTH || pop) q.push_back(wdata[7:0]);
         else set = 1;
      end
      if (dm_wr && mhit && addr[2] && wdata[3]) m_ovf = 0;
      if (set) m_ovf = 1;
      m_busy = busy_n;
   endtask

   task automatic check_outs();
      logic mhit;
      mhit = addr[31:3] == BASE[31:3];
      chk("tx", tx, m_tx());
      chk("busy", busy, m_busy);
      chk("hit", hit, mhit);
      chk("rdata", rdata, (mhit && dm_rd && addr[2]) ? m_status() : 32'h0);
   endtask

   task automatic tick();
      @(negedge clk); check_outs();
      @(posedge clk); model_step();
      #1;
   endtask

   task automatic idle(int n);
      repeat (n) tick();
   endtask

   task automatic store(logic [31:0] a, logic [31:0] d);
      dm_wr = 1; addr = a; wdata = d;
      tick();
      dm_wr = 0; addr = 0; wdata = 0;
   endtask

   task automatic load_chk(string name, logic [31:0] a, logic [31:0] exp);
      dm_rd = 1; addr = a; #1;
      chk(name, rdata, exp);
      dm_rd = 0; addr = 0;
   endtask

   typedef struct {
      logic        wr, rd;
      logic [31:0] a, d;
      logic        ehit;
      logic [31:0] erd;
   } vec_t;
   vec_t vt[8];

   initial begin
      vt[0] = '{0, 1, 32'hFFFF_0000, 0,     1, 0};
      vt[1] = '{0, 1, 32'hFFFF_0004, 0,     1, ST_IDLE};
      vt[2] = '{0, 1, 32'hFFFF_0008, 0,     0, 0};
      vt[3] = '{0, 0, 32'hFFFF_0004, 0,     1, 0};
      vt[4] = '{0, 1, 32'hFFFF_0007, 0,     1, ST_IDLE};
      vt[5] = '{0, 1, 32'hFFFF_0003, 0,     1, 0};
      vt[6] = '{0, 1, 32'hFFFE_0004, 0,     0, 0};
      vt[7] = '{1, 1, 32'hFFFF_000C, 32'hA5, 0, 0};

      // Reset and idle
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_tx", tx, 1);
      chk("reset_busy", busy, 0);
      rst_n = 1;
      load_chk("reset_status", BASE + 4, ST_IDLE);

      // Decode vectors (only the last one writes, and it misses the window)
      for (int i = 0; i < 8; i++) begin
         dm_wr = vt[i].wr; dm_rd = vt[i].rd; addr = vt[i].a; wdata = vt[i].d;
         #1;
         chk($sformatf("vec%0d_hit", i), hit, vt[i].ehit);
         chk($sformatf("vec%0d_rdata", i), rdata, vt[i].erd);
         tick();
      end
      dm_wr = 0; dm_rd = 0; addr = 0; wdata = 0;
      idle(10);
      load_chk("after_vec_status", BASE + 4, ST_IDLE);

      // Single frame
      store(BASE, 32'h0000_00A5);
      tick();
      chk("a5_start_low", tx, 0);
      idle(FLEN + 3);
      chk("a5_busy_done", busy, 0);

      // Back-to-back frames
      store(BASE, 32'h11);
      store(BASE, 32'h22);
      store(BASE, 32'h33);
      load_chk("b2b_count", BASE + 4, 32'h0000_0204 | PBIT);
      idle(3 * FLEN + 10);

      // Overflow
      for (int i = 0; i < 10; i++) store(BASE, 32'h40 + i);
      load_chk("ovf_status", BASE + 4, 32'h0000_080D | PBIT);
      store(BASE + 4, 32'h8);
      load_chk("ovf_clear", BASE + 4, 32'h0000_0805 | PBIT);
      idle(9 * FLEN + 20);
      chk("ovf_drained", busy, 0);

      // Decode and side effects
      dm_wr = 1; addr = BASE + 8; wdata = 32'h77; #1;
      chk("dec_miss_hit", hit, 0);
      tick();
      dm_wr = 0; dm_rd = 1; addr = BASE; #1;
      chk("dec_txdata_hit", hit, 1);
      chk("dec_txdata_rd", rdata, 0);
      tick();
      dm_rd = 0; addr = 0;
      idle(20);
      load_chk("dec_status", BASE + 4, ST_IDLE);

      // Reset during data bit 3 (0xC3 has bit 3 low, so the line is driven 0 there)
      store(BASE, 32'hC3);
      idle(1 + 4 * CD + 1);
      chk("mid_bit3_low", tx, 0);
      #2 rst_n = 0;
      #1 chk("async_tx", tx, 1);
      model_reset();
      idle(2);
      rst_n = 1;
      load_chk("post_reset_status", BASE + 4, ST_IDLE);
      idle(FLEN + 5);

      // Random traffic
      repeat (400) begin
         int r = $urandom_range(0, 9);
         dm_rd = 1'($urandom_range(0, 1));
         dm_wr = (r < 3);
         wdata = $urandom;
         case ($urandom_range(0, 4))
            0, 1: addr = BASE;
            2:    addr = BASE + 4;
            3:    addr = BASE + 8;
            default: addr = BASE | 32'h7;
         endcase
         tick();
      end
      dm_wr = 0; dm_rd = 0; addr = 0;
      idle((DEPTH + 1) * FLEN + 10);
      chk("final_idle", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
